// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared parity codes, FSM state encoding and limits for uart_tx_cfg.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam int MIN_DATA_BITS = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Code 3 is a second spelling of "no parity".
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Per-bit down-counter; bit_end marks the last clock of each bit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             restart,
   input  logic [DIV_W-1:0] reload,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign bit_end = enable && (cnt_q == '0);

   // reload is never zero, so reload-1 cannot underflow.
   always_comb begin
      cnt_d = cnt_q;
      if (restart || bit_end) begin
         cnt_d = reload - DIV_W'(1);
      end else if (enable) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
//  Module   : uart_tx_cfg
//  Brief    : Runtime-configurable UART transmitter (5..MAX data bits, parity,
//             1/2 stop bits, baud divisor). Define UART_TX_FIFO_EN to add a
//             FIFO_DEPTH-entry TX FIFO in front of the frame FSM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int DIV_W         = 32,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [MAX_DATA_BITS-1:0] tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   input  logic [3:0]               data_bits,
   input  logic [1:0]               parity_mode,
   input  logic                     stop_bits,
   input  logic [DIV_W-1:0]         baud_div,
   output logic                     tx,
   output logic                     tx_busy,
   output logic                     tx_sent
);

   localparam logic [3:0] C_MAX_NBITS = 4'(MAX_DATA_BITS);
   localparam logic [3:0] C_MIN_NBITS = 4'(MIN_DATA_BITS);

   tx_state_e                state_q, state_d;
   logic                     tx_q, tx_d;
   logic [MAX_DATA_BITS-1:0] sh_q, sh_d;
   logic [3:0]               nbits_q, nbits_d;
   logic [3:0]               bit_idx_q, bit_idx_d;
   logic                     par_en_q, par_en_d;
   logic                     par_bit_q, par_bit_d;
   logic                     stop2_q, stop2_d;
   logic                     stop_idx_q, stop_idx_d;
   logic [DIV_W-1:0]         div_q, div_d;

   logic                     w_bit_end;
   logic                     w_last_stop;
   logic                     w_can_load;
   logic                     w_load;
   logic                     w_fifo_busy;
   logic [MAX_DATA_BITS-1:0] w_src_data;
   logic [MAX_DATA_BITS-1:0] w_mask;
   logic [MAX_DATA_BITS-1:0] w_src_masked;
   logic [3:0]               w_src_nbits;
   logic [DIV_W-1:0]         w_src_div;
   logic [DIV_W-1:0]         w_reload;

   always_comb begin
      if (data_bits < C_MIN_NBITS) begin
         w_src_nbits = C_MIN_NBITS;
      end else if (data_bits > C_MAX_NBITS) begin
         w_src_nbits = C_MAX_NBITS;
      end else begin
         w_src_nbits = data_bits;
      end
   end

   assign w_src_div    = (baud_div == '0) ? DIV_W'(1) : baud_div;
   assign w_mask       = ~({MAX_DATA_BITS{1'b1}} << w_src_nbits);
   assign w_src_masked = w_src_data & w_mask;

   // Final clock of the final stop bit: frame done, next byte may load here.
   assign w_last_stop = (state_q == ST_STOP) && (stop_idx_q == stop2_q) && w_bit_end;
   assign w_can_load  = (state_q == ST_IDLE) || w_last_stop;

`ifdef UART_TX_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [MAX_DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]           count_q, count_d;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_push;

   assign w_full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign w_empty     = (count_q == '0);
   assign w_push      = tx_valid && !w_full;
   assign w_load      = w_can_load && !w_empty;
   assign w_src_data  = fifo_mem_q[rd_ptr_q];
   assign tx_ready    = !w_full;
   assign w_fifo_busy = !w_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_load) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_load})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_mem_q[wr_ptr_q] <= tx_data;
      end
   end
`else
   assign w_load      = tx_valid && w_can_load;
   assign w_src_data  = tx_data;
   assign tx_ready    = w_can_load;
   assign w_fifo_busy = 1'b0;
`endif

   // A new frame takes its divisor straight from the source, not from div_q.
   assign w_reload = w_load ? w_src_div : div_q;

   uart_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .enable  (state_q != ST_IDLE),
      .restart (w_load),
      .reload  (w_reload),
      .bit_end (w_bit_end)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      sh_d       = sh_q;
      nbits_d    = nbits_q;
      bit_idx_d  = bit_idx_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      stop_idx_d = stop_idx_q;
      div_d      = div_q;

      case (state_q)
         ST_START: begin
            if (w_bit_end) begin
               state_d   = ST_DATA;
               tx_d      = sh_q[0];
               sh_d      = sh_q >> 1;
               bit_idx_d = '0;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               if (bit_idx_q == nbits_q - 4'd1) begin
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d    = ST_STOP;
                     tx_d       = 1'b1;
                     stop_idx_d = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  tx_d      = sh_q[0];
                  sh_d      = sh_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) begin
               state_d    = ST_STOP;
               tx_d       = 1'b1;
               stop_idx_d = 1'b0;
            end
         end
         ST_STOP: begin
            if (w_bit_end) begin
               if (stop_idx_q == stop2_q) begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // Loading overrides the STOP->IDLE exit so back-to-back frames have no gap.
      if (w_load) begin
         state_d   = ST_START;
         tx_d      = 1'b0;
         sh_d      = w_src_masked;
         nbits_d   = w_src_nbits;
         par_en_d  = par_enabled(parity_mode);
         par_bit_d = (^w_src_masked) ^ (parity_mode == PAR_ODD);
         stop2_d   = stop_bits;
         div_d     = w_src_div;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tx_q       <= 1'b1;
         sh_q       <= '0;
         nbits_q    <= '0;
         bit_idx_q  <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_idx_q <= 1'b0;
         div_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         sh_q       <= sh_d;
         nbits_q    <= nbits_d;
         bit_idx_q  <= bit_idx_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         stop_idx_q <= stop_idx_d;
         div_q      <= div_d;
      end
   end

   assign tx      = tx_q;
   assign tx_sent = w_last_stop;
   assign tx_busy = (state_q != ST_IDLE) || w_fifo_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
//  Module   : tb_uart_tx_cfg
//  Brief    : Scoreboard bench for uart_tx_cfg; expected frames are queued at
//             accept and compared bit-by-bit against the tx line.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [3:0]  data_bits = 4'd8;
   logic [1:0]  parity_mode = 2'd0;
   logic        stop_bits = 1'b0;
   logic [31:0] baud_div = 32'd1;
   logic        tx;
   logic        tx_busy;
   logic        tx_sent;

   uart_tx_cfg #(
      .MAX_DATA_BITS (9),
      .DIV_W         (32),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .data_bits   (data_bits),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .baud_div    (baud_div),
      .tx          (tx),
      .tx_busy     (tx_busy),
      .tx_sent     (tx_sent)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] lv;
      int          nb;
      int          dv;
      int          start;
   } frame_t;

   frame_t exp_q[$];
   int     sent_log[$];
   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;
   bit     in_frame = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference frame: start, data LSB first, optional parity, stop bits.
   function automatic frame_t mk_frame(input logic [8:0] d, input int nb, input int pm,
                                       input int sb, input int dv, input int st);
      frame_t f;
      int     n;
      int     i;
      logic   p;
      n = (nb < 5) ? 5 : ((nb > 9) ? 9 : nb);
      p = 1'b0;
      f.lv = '1;
      f.lv[0] = 1'b0;
      for (int j = 0; j < n; j++) begin
         f.lv[1+j] = d[j];
         p = p ^ d[j];
      end
      i = 1 + n;
      if (pm == 1) begin
         f.lv[i] = p;
         i++;
      end else if (pm == 2) begin
         f.lv[i] = ~p;
         i++;
      end
      f.nb    = i + (sb != 0 ? 2 : 1);
      f.dv    = (dv == 0) ? 1 : dv;
      f.start = st;
      return f;
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      frame_t cur;
      int     k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
         if (rst) begin
            in_frame = 1'b0;
            check("rst_tx", tx, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_sent", tx_sent, 0);
            check("rst_ready", tx_ready, 1);
         end else begin
            if (!in_frame && tx == 1'b0) begin
               if (exp_q.size() == 0) begin
                  check("spurious_start", tx, 1);
               end else begin
                  cur = exp_q.pop_front();
                  in_frame = 1'b1;
                  k = 0;
                  if (cur.start >= 0) check("start_cyc", cyc, cur.start);
               end
            end
            if (in_frame) begin
               check("tx_bit", tx, cur.lv[k / cur.dv]);
               check("sent", tx_sent, (k == cur.nb * cur.dv - 1));
               check("busy", tx_busy, 1);
`ifndef UART_TX_FIFO_EN
               check("ready_in_frame", tx_ready, (k == cur.nb * cur.dv - 1));
`endif
               if (k == cur.nb * cur.dv - 1) begin
                  in_frame = 1'b0;
                  sent_log.push_back(cyc);
               end
               k++;
            end else begin
               check("idle_sent", tx_sent, 0);
            end
         end
      end
   end

   // Called at a falling edge; returns at a falling edge with tx_valid still high.
   task automatic send(input logic [8:0] d, input int nb, input int pm, input int sb,
                       input int dv, output int acc);
      bit     ok;
      int     st;
      tx_data     = d;
      data_bits   = 4'(nb);
      parity_mode = 2'(pm);
      stop_bits   = (sb != 0);
      baud_div    = 32'(dv);
      tx_valid    = 1'b1;
      ok  = 1'b0;
      acc = -1;
      for (int t = 0; t < 2000 && !ok; t++) begin
         if (tx_ready) begin
            ok  = 1'b1;
            acc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) begin
         check("accept_timeout", tx_ready, 1);
         tx_valid = 1'b0;
      end else begin
`ifdef UART_TX_FIFO_EN
         st = -1;
`else
         st = acc + 1;
`endif
         exp_q.push_back(mk_frame(d, nb, pm, sb, dv, st));
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int t;
      tx_valid = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || in_frame) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", exp_q.size() + int'(in_frame), 0);
      @(negedge clk);
      check("idle_busy", tx_busy, 0);
      check("idle_tx", tx, 1);
   endtask

   initial begin
      int a0, a1;
      int n0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 8N1, divisor 4
      send(9'h0A5, 8, 0, 0, 4, a0);
      drain();

      // 8E1 with config disturbed mid-frame, then 8O1
      send(9'h0A5, 8, 1, 0, 2, a0);
      repeat (3) @(negedge clk);
      data_bits = 4'd5; parity_mode = 2'd2; stop_bits = 1'b1; baud_div = 32'd7; tx_data = '0;
      drain();
      send(9'h0A5, 8, 2, 0, 2, a0);
      drain();

      // 5N2 with upper data bits set
      send(9'h1F3, 5, 0, 1, 1, a0);
      drain();

      // Clamping: data_bits 15 -> 9, data_bits 2 -> 5, divisor 0 -> 1
      send(9'h155, 15, 2, 0, 0, a0);
      drain();
      send(9'h0EB, 2, 1, 1, 0, a0);
      drain();
      send(9'h0C3, 8, 3, 0, 1, a0);
      drain();

      // Back-to-back with tx_valid held high
      n0 = sent_log.size();
      send(9'h055, 8, 0, 0, 3, a0);
      send(9'h00F, 8, 0, 0, 3, a1);
      drain();
      check("b2b_count", sent_log.size() - n0, 2);
      if (sent_log.size() - n0 == 2) check("b2b_spacing", sent_log[n0+1] - sent_log[n0], 30);
`ifndef UART_TX_FIFO_EN
      check("b2b_accept_last_stop", a1, a0 + 30);
`endif

      // Reset in the middle of a frame
      send(9'h0A5, 8, 0, 0, 4, a0);
      tx_valid = 1'b0;
      while (cyc < a0 + 15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(9'h03C, 8, 1, 0, 2, a1);
      check("post_rst_accept", a1, a0 + 16);
      drain();

`ifdef UART_TX_FIFO_EN
      // Fill the FIFO while the first byte is on the line
      send(9'h011, 8, 0, 0, 0, a0);
      send(9'h022, 8, 0, 0, 0, a0);
      send(9'h033, 8, 0, 0, 0, a0);
      send(9'h044, 8, 0, 0, 0, a0);
      send(9'h055, 8, 0, 0, 0, a0);
      check("fifo_full_ready", tx_ready, 0);
      check("fifo_busy", tx_busy, 1);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
